duty_sequencer: RTL
===================

# duty_sequencer

Generates the 4-bit `duty_cycle` word for the `pwm` stage of the LED dimmer. It supports static, breathing (triangle fade) and blink modes. Duty changes take effect only at PWM period boundaries, so the downstream PWM never produces a truncated or glitched period. It runs a 16-clock phase counter that stays in lock-step with the PWM's internal counter, because both come out of reset on the same edge.

## Interface
- `DUTY_W`, 4: duty width; the PWM period is 2^DUTY_W clocks.
- `DIV_W`, 16: width of the step divider.
- `clk`  in  1: system clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset. The single clock is `clk`.
- `enable`  in  1: 0 forces the output toward 0/IDLE; 1 runs the selected mode.
- `mode`  in  2: 00 static, 01 breathe, 10 blink, 11 reserved (behaves as static).
- `static_duty`  in  DUTY_W: duty used in static mode.
- `step_div`  in  DIV_W: number of PWM periods per step. A value of 0 is treated as 1.
- `duty_cycle`  out  DUTY_W: registered duty word, connected to `pwm.duty_cycle`.
- `period_tick`  out  1: one-clock pulse while the phase counter equals 2^DUTY_W−1.
- `cycle_done`  out  1: one-clock pulse when a breathe or blink cycle completes.

## Operation
- Phase counter `phase` runs 0..15 and wraps. A boundary is the clock where `phase`==15.
- All sampling of `enable`, `mode`, `static_duty` and `step_div`, and every update of `duty_cycle`, happens only at a boundary. Between boundaries `duty_cycle` is constant.
- Step counter `step_cnt` advances once per boundary. A step occurs when `step_cnt` == max(`step_div`,1)−1; `step_cnt` then returns to 0.
- `step_cnt` clears to 0 at any boundary where the state-selecting mode changes.
- States:
  - IDLE: `duty_cycle`=0.
  - STATIC: `duty_cycle`=`static_duty` at every boundary.
  - RAMP_UP: on a step, `duty_cycle`+1. On the step where 15 is reached, go to RAMP_DOWN.
  - RAMP_DOWN: on a step, `duty_cycle`−1. On the step where 0 is reached, pulse `cycle_done` and go to RAMP_UP.
  - BLINK_ON: `duty_cycle`=15. On a step, go to BLINK_OFF.
  - BLINK_OFF: `duty_cycle`=0. On a step, pulse `cycle_done` and go to BLINK_ON.
- Transitions at a boundary:
  - `enable`=0 from any state → IDLE, `duty_cycle`=0.
  - `enable`=1 from IDLE or after a mode change:
    - Static → STATIC.
    - Breathe → RAMP_UP, starting from the current `duty_cycle`. If that value is 15, go to RAMP_DOWN instead.
    - Blink → BLINK_ON, `duty_cycle`=15 immediately.
- Arithmetic saturates: the value never wraps past 15 or below 0.
- Changing `step_div` mid-count compares against the new value at the next boundary. If `step_cnt` is already ≥ the new limit, the step occurs at that boundary.

## Timing
- Reset values: `phase`=0, `step_cnt`=0, state=IDLE, `duty_cycle`=0, `period_tick`=0, `cycle_done`=0.
- When `reset_n` is asserted mid-operation, all state clears at once with no wait for a boundary.
- `duty_cycle` is written on the rising edge that ends phase 15, so it is valid throughout phase 0..15 of the next period.
  - Latency from an input change to the output is 1–16 clocks.
  - Combined with the PWM's registered output, the new duty is visible on the pin one clock after the period start.
- `period_tick` is combinational from `phase`, high during phase 15, and repeats every 16 clocks.
- `cycle_done` is registered and asserts in the same clock as the `duty_cycle` update that ends the cycle.
- A full breathe cycle lasts 30·max(`step_div`,1)·16 clocks.
- A full blink cycle lasts 2·max(`step_div`,1)·16 clocks.

## Structure
- A shared package `dimmer_pkg` holds:
  - the state encodings (IDLE, STATIC, RAMP_UP, RAMP_DOWN, BLINK_ON, BLINK_OFF);
  - the mode constants `MODE_STATIC`=2'b00, `MODE_BREATHE`=2'b01, `MODE_BLINK`=2'b10;
  - `DUTY_MAX`=4'hF.
- One sub-module is natural: `period_timer`, which contains the phase counter, `period_tick`, and the `step_cnt`/step-strobe generation. The FSM and duty register live in the top module.

## Test plan
- Reset held for 3 clocks, then released with `enable`=0 → `duty_cycle`=0, `period_tick` first high at clock 15 after release, then every 16 clocks.
- Static: `enable`=1, `mode`=00, `static_duty`=9 applied at phase 4 → `duty_cycle` stays 0 until the edge ending phase 15, then reads 9 and remains stable through the period.
- Breathe: `step_div`=1 starting from 0 → `duty_cycle` reads 1,2,…,15,14,…,0 on successive boundaries; `cycle_done` pulses exactly once when 0 is reached (30 periods = 480 clocks).
- Blink: `step_div`=2 → output 15 for 32 clocks, then 0 for 32 clocks; `cycle_done` pulses at the 15→0→15 transition edge.
- Boundary cases:
  - `step_div`=0 behaves identically to 1.
  - `mode` changed 01→10 while at duty 7 → `duty_cycle`=15 at the next boundary, with `step_cnt` cleared.
- `reset_n` pulsed low mid-ramp at duty 11 → all outputs read 0 within the same clock; `phase` restarts at 0.

Source files
------------

// File: rtl/dimmer_pkg.sv
// Shared definitions for the LED dimmer duty sequencer.
//   - state_t      : duty sequencer FSM states
//   - MODE_*       : encodings of the two-bit mode input
//   - DUTY_MAX     : full-scale duty word
//   - select_mode  : folds the reserved mode onto static
//   - state_mode   : mode a state belongs to (IDLE belongs to none)
package dimmer_pkg;

    localparam logic [1:0] MODE_STATIC  = 2'b00;
    localparam logic [1:0] MODE_BREATHE = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_NONE    = 2'b11;

    localparam logic [3:0] DUTY_MAX = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        STATIC,
        RAMP_UP,
        RAMP_DOWN,
        BLINK_ON,
        BLINK_OFF
    } state_t;

    // Reserved mode 2'b11 behaves as static.
    function automatic logic [1:0] select_mode(input logic [1:0] mode);
        return (mode == MODE_NONE) ? MODE_STATIC : mode;
    endfunction

    // IDLE maps to MODE_NONE, which select_mode never returns, so leaving
    // IDLE always looks like a mode change.
    function automatic logic [1:0] state_mode(input state_t state);
        logic [1:0] m;
        case (state)
            STATIC:              m = MODE_STATIC;
            RAMP_UP, RAMP_DOWN:  m = MODE_BREATHE;
            BLINK_ON, BLINK_OFF: m = MODE_BLINK;
            default:             m = MODE_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/period_timer.sv
// PWM period timer for the duty sequencer.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   step_div       : PWM periods per step (0 treated as 1)
//   clear          : restart the step count at this boundary
//   period_tick    : high while the phase counter is at its last value
//   step           : high on a boundary that completes a step
module period_timer #(
    parameter int PHASE_W = 4,
    parameter int DIV_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] step_div,
    input  logic             clear,
    output logic             period_tick,
    output logic             step
);

    logic [PHASE_W-1:0] phase;
    logic [DIV_W-1:0]   step_cnt;
    logic [DIV_W-1:0]   last_cnt;

    // Last count value of a step; a divider of 0 behaves as 1.
    assign last_cnt    = (step_div == '0) ? '0 : step_div - DIV_W'(1);
    assign period_tick = &phase;
    // ">=" rather than "==" so a divider lowered below the running count
    // steps at the next boundary instead of waiting for a counter wrap.
    assign step        = period_tick && (step_cnt >= last_cnt);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            step_cnt <= '0;
        end else begin
            phase <= phase + PHASE_W'(1);
            if (period_tick) begin
                if (clear || step) step_cnt <= '0;
                else               step_cnt <= step_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/duty_sequencer.sv
// Duty word sequencer for the LED dimmer PWM stage: static, breathe
// (triangle fade) and blink modes, updated only at PWM period boundaries.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : 0 drives the output to 0 (IDLE)
//   mode         : 00 static, 01 breathe, 10 blink, 11 static
//   static_duty  : duty used in static mode
//   step_div     : PWM periods per breathe/blink step (0 treated as 1)
//   duty_cycle   : registered duty word for the PWM
//   period_tick  : high during the last clock of each PWM period
//   cycle_done   : one-clock pulse when a breathe or blink cycle ends
module duty_sequencer
    import dimmer_pkg::*;
#(
    parameter int DUTY_W = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DUTY_W-1:0] static_duty,
    input  logic [DIV_W-1:0]  step_div,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              period_tick,
    output logic              cycle_done
);

    localparam logic [DUTY_W-1:0] FULL = DUTY_W'(DUTY_MAX);

    state_t            state, state_nx;
    logic [DUTY_W-1:0] duty_nx;
    logic              done_nx;
    logic [1:0]        sel;
    logic              enter;
    logic              step;

    assign sel   = select_mode(mode);
    assign enter = enable && (sel != state_mode(state));

    period_timer #(
        .PHASE_W (DUTY_W),
        .DIV_W   (DIV_W)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .step_div    (step_div),
        .clear       (enter),
        .period_tick (period_tick),
        .step        (step)
    );

    // NOTE: every variable gets a hold/idle default first so no path through
    // the case statements can infer a latch.
    always_comb begin
        state_nx = state;
        duty_nx  = duty_cycle;
        done_nx  = 1'b0;
        if (period_tick) begin
            if (!enable) begin
                state_nx = IDLE;
                duty_nx  = '0;
            end else if (enter) begin
                case (sel)
                    MODE_BREATHE: state_nx = (duty_cycle == FULL) ? RAMP_DOWN : RAMP_UP;
                    MODE_BLINK: begin
                        state_nx = BLINK_ON;
                        duty_nx  = FULL;
                    end
                    default: begin
                        state_nx = STATIC;
                        duty_nx  = static_duty;
                    end
                endcase
            end else begin
                case (state)
                    STATIC: duty_nx = static_duty;
                    RAMP_UP: if (step) begin
                        if (duty_cycle >= FULL - DUTY_W'(1)) begin
                            duty_nx  = FULL;
                            state_nx = RAMP_DOWN;
                        end else begin
                            duty_nx = duty_cycle + DUTY_W'(1);
                        end
                    end
                    RAMP_DOWN: if (step) begin
                        if (duty_cycle <= DUTY_W'(1)) begin
                            duty_nx  = '0;
                            state_nx = RAMP_UP;
                            done_nx  = 1'b1;
                        end else begin
                            duty_nx = duty_cycle - DUTY_W'(1);
                        end
                    end
                    BLINK_ON: if (step) begin
                        duty_nx  = '0;
                        state_nx = BLINK_OFF;
                    end
                    BLINK_OFF: if (step) begin
                        duty_nx  = FULL;
                        state_nx = BLINK_ON;
                        done_nx  = 1'b1;
                    end
                    default: begin
                        state_nx = IDLE;
                        duty_nx  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            duty_cycle <= '0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nx;
            duty_cycle <= duty_nx;
            cycle_done <= done_nx;
        end
    end

endmodule
